// File: rtl/acc_16bit_if.sv
// acc_16bit_if: command, stream and result signals of the 16-bit accumulator.
//   master: drives start/len/din/din_valid, observes din_ready and results.
//   slave : the accumulator side (acc_16bit).
// Signals:
//   start, len           - begin a job of len words (sampled in IDLE)
//   din, din_valid       - input word stream
//   din_ready            - accumulator accepts din this cycle
//   sum, carry_cnt, ovf  - result; the total is {carry_cnt, sum}
//   busy, done           - job in progress / one-cycle completion pulse
interface acc_16bit_if #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [15:0]      din;
    logic             din_valid;
    logic             din_ready;
    logic [15:0]      sum;
    logic [CNT_W-1:0] carry_cnt;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, len, din, din_valid,
        input  din_ready, sum, carry_cnt, ovf, busy, done
    );

    modport slave (
        input  start, len, din, din_valid,
        output din_ready, sum, carry_cnt, ovf, busy, done
    );
endinterface

// File: rtl/acc_16bit.sv
// acc_16bit: streaming accumulator built around a 16-bit ripple-carry adder.
// Sums len words accepted under a valid/ready handshake; adder carry-outs are
// counted (saturating) in carry_cnt, which extends sum to {carry_cnt, sum}.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - acc_16bit_if.slave (start/len/din/din_valid in;
//          din_ready/sum/carry_cnt/ovf/busy/done out)

// rc_16bit: combinational 16-bit ripple-carry adder.
//   a, b - operands; cin - carry in; s - sum; cout - carry out
module rc_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [16:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 16; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[16];
endmodule

module acc_16bit #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    acc_16bit_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [15:0]      sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [LEN_W-1:0] remaining;

    logic [15:0]      add_s;
    logic             add_cout;
    logic             xfer;

    // Running sum on a, incoming word on b; carries are tracked in cnt_q.
    rc_16bit u_add (
        .a    (sum_q),
        .b    (bus.din),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    // din_ready is a pure state decode, so a transfer is RUN & din_valid.
    assign xfer = (state == RUN) && bus.din_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sum_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sum_q     <= '0;
                        cnt_q     <= '0;
                        ovf_q     <= 1'b0;
                        remaining <= bus.len;
                        state     <= (bus.len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        sum_q     <= add_s;
                        remaining <= remaining - LEN_W'(1);
                        if (add_cout) begin
                            if (cnt_q == '1) begin
                                ovf_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        if (remaining == LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.din_ready = (state == RUN);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_cnt = cnt_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_acc_16bit.sv
module tb_acc_16bit;
    logic clk;
    logic rst;

    acc_16bit_if #(.LEN_W(8), .CNT_W(8)) bus  ();
    acc_16bit_if #(.LEN_W(8), .CNT_W(2)) bus2 ();

    acc_16bit #(.LEN_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    acc_16bit #(.LEN_W(8), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] words [16];
    int          checks;
    int          passed;

    // Reference: plain wide addition, carry counter saturating at cmax.
    function automatic exp_t model(input int n, input int cmax);
        exp_t        e;
        logic [16:0] t;
        e.sum = '0;
        e.cnt = '0;
        e.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            t = {1'b0, e.sum} + {1'b0, words[i]};
            e.sum = t[15:0];
            if (t[16]) begin
                if (e.cnt == 32'(cmax)) e.ovf = 1'b1;
                else e.cnt = e.cnt + 1;
            end
        end
        return e;
    endfunction

    // Drives one job on bus; pushes the expected result when stimulus starts.
    task automatic run_job(input int n, input bit gaps, input bit poke,
                           output int xfers, output int done_cnt, output int done_cyc,
                           output bit ready_seen, output bit timed_out,
                           output logic [15:0] s_at, output logic [7:0] c_at,
                           output logic o_at);
        int idx;
        int gap_left;
        bit finished;
        bit poked;
        int gap_tab [4];
        gap_tab = '{0, 1, 2, 3};
        xfers = 0; done_cnt = 0; done_cyc = -1; ready_seen = 0;
        finished = 0; poked = 0; idx = 0;
        s_at = 'x; c_at = 'x; o_at = 1'bx;
        gap_left = gaps ? gap_tab[0] : 0;
        exp_q.push_back(model(n, 255));
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'(n);
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = 8'($urandom);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    s_at = bus.sum;
                    c_at = bus.carry_cnt;
                    o_at = bus.ovf;
                end
            end else if (done_cnt > 0) begin
                finished = 1;
                break;
            end
            if (bus.din_ready) ready_seen = 1;
            bus.start = 1'b0;
            if (idx < n && gap_left == 0) begin
                bus.din_valid = 1'b1;
                bus.din       = words[idx];
                if (bus.din_ready) begin
                    xfers++;
                    idx++;
                    gap_left = gaps ? gap_tab[idx % 4] : 0;
                end
            end else begin
                bus.din_valid = 1'b0;
                bus.din       = 16'($urandom);
                if (gap_left > 0) gap_left--;
            end
            if (poke && idx == 1 && !poked) begin
                bus.start = 1'b1;
                bus.len   = 8'd7;
                poked     = 1;
            end
            @(negedge clk);
        end
        bus.din_valid = 1'b0;
        bus.start     = 1'b0;
        timed_out = !finished;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 0; bus.len = '0; bus.din = '0; bus.din_valid = 0;
        bus2.start = 0; bus2.len = '0; bus2.din = '0; bus2.din_valid = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.sum, bus.carry_cnt, bus.ovf, bus.busy, bus.done, bus.din_ready} !== '0)
            $display("FAIL reset_outputs: got sum=%h cnt=%h ovf=%b busy=%b done=%b rdy=%b, expected all 0",
                     bus.sum, bus.carry_cnt, bus.ovf, bus.busy, bus.done, bus.din_ready);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.din_ready} !== 3'b000)
            $display("FAIL reset_idle: got busy/done/rdy=%b, expected 000", {bus.busy, bus.done, bus.din_ready});
        else passed++;
    endtask

    task automatic test_reset_midrun;
        int x, dc, dcy; bit rs, to; logic [15:0] s; logic [7:0] c; logic o; exp_t e;
        @(negedge clk);
        bus.start = 1'b1; bus.len = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        bus.din_valid = 1'b1; bus.din = 16'h1234;
        @(negedge clk);
        bus.din = 16'h1111;
        @(negedge clk);
        bus.din_valid = 1'b0;
        checks++;
        if (bus.sum !== 16'h2345 || bus.busy !== 1'b1)
            $display("FAIL midrun_partial: got sum=%h busy=%b, expected sum=2345 busy=1", bus.sum, bus.busy);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.sum, bus.carry_cnt, bus.ovf, bus.busy, bus.done, bus.din_ready} !== '0)
            $display("FAIL midrun_reset: got sum=%h cnt=%h ovf=%b busy=%b done=%b rdy=%b, expected all 0",
                     bus.sum, bus.carry_cnt, bus.ovf, bus.busy, bus.done, bus.din_ready);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        words[0] = 16'h0005;
        run_job(1, 0, 0, x, dc, dcy, rs, to, s, c, o);
        e = exp_q.pop_front();
        checks++;
        if (to || s !== e.sum || {24'b0, c} !== e.cnt)
            $display("FAIL after_reset_job: got sum=%h cnt=%h timeout=%b, expected sum=%h cnt=%0d",
                     s, c, to, e.sum, e.cnt);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int x, dc, dcy; bit rs, to; logic [15:0] s; logic [7:0] c; logic o; exp_t e;
        words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
        run_job(3, 0, 0, x, dc, dcy, rs, to, s, c, o);
        e = exp_q.pop_front();
        checks++;
        if (to || s !== e.sum || {24'b0, c} !== e.cnt || o !== e.ovf)
            $display("FAIL b2b_result: got sum=%h cnt=%h ovf=%b, expected sum=%h cnt=%0d ovf=%b",
                     s, c, o, e.sum, e.cnt, e.ovf);
        else passed++;
        checks++;
        if (dc !== 1 || dcy !== 3)
            $display("FAIL b2b_done_pulse: got %0d cycles at offset %0d, expected 1 at 3", dc, dcy);
        else passed++;
        checks++;
        if (x !== 3)
            $display("FAIL b2b_transfers: got %0d, expected 3", x);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.sum !== 16'h0006 || bus.busy !== 1'b0)
            $display("FAIL b2b_hold: got sum=%h busy=%b, expected sum=0006 busy=0", bus.sum, bus.busy);
        else passed++;
    endtask

    task automatic test_carry;
        int x, dc, dcy; bit rs, to; logic [15:0] s; logic [7:0] c; logic o; exp_t e;
        words[0] = 16'hFFFF; words[1] = 16'h0002;
        run_job(2, 0, 0, x, dc, dcy, rs, to, s, c, o);
        e = exp_q.pop_front();
        checks++;
        if (to || s !== e.sum || {24'b0, c} !== e.cnt || o !== 1'b0)
            $display("FAIL carry_result: got sum=%h cnt=%h ovf=%b, expected sum=%h cnt=%0d ovf=0",
                     s, c, o, e.sum, e.cnt);
        else passed++;
    endtask

    task automatic test_len_zero;
        int x, dc, dcy; bit rs, to; logic [15:0] s; logic [7:0] c; logic o; exp_t e;
        run_job(0, 0, 0, x, dc, dcy, rs, to, s, c, o);
        e = exp_q.pop_front();
        checks++;
        if (to || dcy !== 0 || dc !== 1)
            $display("FAIL len0_done: got offset=%0d cycles=%0d timeout=%b, expected offset 0 cycles 1", dcy, dc, to);
        else passed++;
        checks++;
        if (s !== e.sum || rs !== 1'b0 || x !== 0)
            $display("FAIL len0_result: got sum=%h ready_seen=%b xfers=%0d, expected sum=%h ready_seen=0 xfers=0",
                     s, rs, x, e.sum);
        else passed++;
    endtask

    task automatic test_handshake;
        int x, dc, dcy; bit rs, to; logic [15:0] s; logic [7:0] c; logic o; exp_t e;
        words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
        run_job(3, 1, 1, x, dc, dcy, rs, to, s, c, o);
        e = exp_q.pop_front();
        checks++;
        if (to || s !== e.sum || {24'b0, c} !== e.cnt || o !== e.ovf)
            $display("FAIL gaps_result: got sum=%h cnt=%h ovf=%b, expected sum=%h cnt=%0d ovf=%b",
                     s, c, o, e.sum, e.cnt, e.ovf);
        else passed++;
        checks++;
        if (x !== 3 || dc !== 1)
            $display("FAIL gaps_count: got xfers=%0d done_cycles=%0d, expected 3 and 1", x, dc);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0)
            $display("FAIL gaps_start_ignored: got busy=%b, expected 0", bus.busy);
        else passed++;
    endtask

    task automatic test_saturation;
        exp_t e;
        bit   seen;
        for (int i = 0; i < 5; i++) words[i] = 16'hFFFF;
        exp_q.push_back(model(5, 3));
        @(negedge clk);
        bus2.start = 1'b1; bus2.len = 8'd5;
        @(negedge clk);
        bus2.start = 1'b0;
        bus2.din_valid = 1'b1; bus2.din = 16'hFFFF;
        seen = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (bus2.done) begin
                seen = 1;
                break;
            end
        end
        bus2.din_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!seen || bus2.sum !== e.sum || {30'b0, bus2.carry_cnt} !== e.cnt || bus2.ovf !== e.ovf)
            $display("FAIL sat_result: got sum=%h cnt=%h ovf=%b done=%b, expected sum=%h cnt=%0d ovf=%b",
                     bus2.sum, bus2.carry_cnt, bus2.ovf, seen, e.sum, e.cnt, e.ovf);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (bus2.ovf !== 1'b1 || bus2.carry_cnt !== 2'b11)
            $display("FAIL sat_sticky: got ovf=%b cnt=%h, expected ovf=1 cnt=3", bus2.ovf, bus2.carry_cnt);
        else passed++;
        bus2.start = 1'b1; bus2.len = 8'd1;
        @(negedge clk);
        bus2.start = 1'b0;
        checks++;
        if (bus2.ovf !== 1'b0 || bus2.carry_cnt !== 2'b00 || bus2.sum !== 16'h0000 || bus2.din_ready !== 1'b1)
            $display("FAIL sat_clear: got ovf=%b cnt=%h sum=%h rdy=%b, expected 0 0 0000 1",
                     bus2.ovf, bus2.carry_cnt, bus2.sum, bus2.din_ready);
        else passed++;
        bus2.din_valid = 1'b1; bus2.din = 16'h0001;
        @(negedge clk);
        bus2.din_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_back_to_back();
        test_carry();
        test_len_zero();
        test_handshake();
        test_reset_midrun();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
